// File: rtl/d_cache_nway.sv
// d_cache_nway -- N-way set-associative, write-back, write-allocate data cache.
//
// Sits between the pipeline MEM stage (30-bit word address) and a 128-bit
// block memory. Lookups in IDLE answer combinationally. A miss picks a victim
// (lowest invalid way, otherwise tree pseudo-LRU), writes it back if dirty,
// fills the block, then returns to IDLE where the held request retries and hits.
//
// Parameters:
//   WAYS  associativity (1, 2, 4, 8)
//   SETS  number of sets (power of two, 2..64)
//
// Ports:
//   clk, proc_reset           clock (rising edge), async active-high reset
//   proc_read, proc_write     load / store request (both high = store)
//   proc_addr[29:0]           word address {tag, index, word offset[1:0]}
//   proc_wdata, proc_rdata    store data in, load data out
//   proc_stall                request cannot complete this cycle
//   mem_read, mem_write       block fill / writeback request
//   mem_addr[27:0]            block address {tag, index}
//   mem_rdata, mem_wdata      128-bit fill / writeback data, word k at [32k+31:32k]
//   mem_ready                 memory completion strobe
//
// Optional build macro D_CACHE_PERF_CNT_EN adds saturating 32-bit counters
// perf_hits, perf_misses and perf_wbs.

module d_cache_nway #(
    parameter int WAYS = 2,
    parameter int SETS = 4
) (
    input  logic         clk,
    input  logic         proc_reset,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    output logic [31:0]  proc_rdata,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    input  logic [127:0] mem_rdata,
    output logic [127:0] mem_wdata,
    input  logic         mem_ready
`ifdef D_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses,
    output logic [31:0]  perf_wbs
`endif
);

    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 28 - IDX_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_FILL = 2'd2;

    // Tree PLRU: node n has children 2n+1 (bit=0 side) and 2n+2 (bit=1 side).
    // Each bit points toward the less recently used subtree.
    function automatic logic [WAY_W-1:0] plru_pick(input logic [PLRU_W-1:0] bits);
        logic [WAY_W-1:0] way;
        logic             b;
        int               node;
        way  = '0;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = 1'b0;
            for (int n = 0; n < PLRU_W; n++)
                if (n == node) b = bits[n];
            way  = (way << 1) | WAY_W'(b);
            node = 2 * node + 1 + int'(b);
        end
        return way;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] bits,
                                                     input logic [WAY_W-1:0]  way);
        logic [PLRU_W-1:0] nb;
        logic [WAY_W-1:0]  w;
        logic              dir;
        int                node;
        nb   = bits;
        w    = way;
        node = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = w[WAY_W-1];
            w   = w << 1;
            // Point this node away from the way just used.
            for (int n = 0; n < PLRU_W; n++)
                if (n == node) nb[n] = ~dir;
            node = 2 * node + 1 + int'(dir);
        end
        return nb;
    endfunction

    // Address decode
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       off;
    assign off = proc_addr[1:0];
    assign idx = proc_addr[IDX_W+1:2];
    assign tag = proc_addr[29:IDX_W+2];

    // Storage
    logic [1:0]       state_q;
    logic [WAY_W-1:0] victim_q;
    logic [WAYS-1:0]  valid_q [SETS];
    logic [WAYS-1:0]  dirty_q [SETS];
    logic [TAG_W-1:0] tag_q   [SETS][WAYS];
    logic [127:0]     data_q  [SETS][WAYS];

    logic             req, lookup, hit, hit_now, miss_now, inv_found;
    logic [WAY_W-1:0] hit_way, victim_nxt, plru_victim;
    logic [127:0]     hit_block;

    assign req      = proc_read | proc_write;
    assign lookup   = (state_q == S_IDLE) && req;
    assign hit_now  = lookup && hit;
    assign miss_now = lookup && !hit;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Prefer the lowest invalid way; only a full set consults the PLRU tree.
    always_comb begin
        victim_nxt = plru_victim;
        inv_found  = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!inv_found && !valid_q[idx][w]) begin
                victim_nxt = WAY_W'(w);
                inv_found  = 1'b1;
            end
        end
    end

    generate
        if (WAYS > 1) begin : g_plru
            logic [PLRU_W-1:0] plru_q [SETS];

            always_ff @(posedge clk or posedge proc_reset) begin
                if (proc_reset) begin
                    for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
                end else if (hit_now) begin
                    plru_q[idx] <= plru_touch(plru_q[idx], hit_way);
                end
            end

            assign plru_victim = plru_pick(plru_q[idx]);
        end else begin : g_no_plru
            assign plru_victim = '0;
        end
    endgenerate

    // Outputs. Gating with proc_reset makes the processor side quiet for the
    // whole time reset is held, even with a request still driven.
    assign hit_block  = data_q[idx][hit_way];
    assign proc_rdata = (!proc_reset && hit_now) ? hit_block[{off, 5'b0} +: 32] : 32'h0;
    assign proc_stall = !proc_reset && (miss_now || (state_q != S_IDLE));
    assign mem_write  = (state_q == S_WB);
    assign mem_read   = (state_q == S_FILL);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_WB: begin
                mem_addr  = {tag_q[idx][victim_q], idx};
                mem_wdata = data_q[idx][victim_q];
            end
            S_FILL:  mem_addr = proc_addr[29:2];
            default: ;
        endcase
    end

    // Control state. The request is held stable while stalled, so idx still
    // names the set being serviced throughout WB and FILL.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit_now && proc_write) begin
                        dirty_q[idx][hit_way] <= 1'b1;
                    end else if (miss_now) begin
                        victim_q <= victim_nxt;
                        state_q  <= dirty_q[idx][victim_nxt] ? S_WB : S_FILL;
                    end
                end
                S_WB: begin
                    if (mem_ready) begin
                        dirty_q[idx][victim_q] <= 1'b0;
                        state_q                <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        valid_q[idx][victim_q] <= 1'b1;
                        dirty_q[idx][victim_q] <= 1'b0;
                        state_q                <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone decide
    // whether their contents mean anything, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        if (hit_now && proc_write)
            data_q[idx][hit_way][{off, 5'b0} +: 32] <= proc_wdata;
        if ((state_q == S_FILL) && mem_ready) begin
            data_q[idx][victim_q] <= mem_rdata;
            tag_q[idx][victim_q]  <= tag;
        end
    end

`ifdef D_CACHE_PERF_CNT_EN
    // retry_q marks the IDLE cycle right after a fill, where the held request
    // re-executes; that cycle is not a new request and is not counted.
    logic retry_q;

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            retry_q     <= 1'b0;
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            if ((state_q == S_FILL) && mem_ready)
                retry_q <= 1'b1;
            else if (state_q == S_IDLE)
                retry_q <= 1'b0;

            if (lookup && !retry_q) begin
                if (hit) begin
                    if (perf_hits != '1) perf_hits <= perf_hits + 32'd1;
                end else begin
                    if (perf_misses != '1) perf_misses <= perf_misses + 32'd1;
                end
            end

            if ((state_q == S_WB) && mem_ready && (perf_wbs != '1))
                perf_wbs <= perf_wbs + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_d_cache_nway.sv
// tb_d_cache_nway -- self-checking bench for d_cache_nway (WAYS=2, SETS=4).
// A vector table drives processor accesses; expected load data and expected
// memory transactions are queued when each access is driven and compared when
// the cache produces them. A behavioural memory answers fills/writebacks after
// LAT wait cycles. Hand-written sequences cover stray mem_ready, read+write
// together and reset during a writeback.

module tb_d_cache_nway;

    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         proc_reset, proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata, proc_rdata;
    logic         proc_stall, mem_read, mem_write, mem_ready;
    logic [27:0]  mem_addr;
    logic [127:0] mem_rdata, mem_wdata;
`ifdef D_CACHE_PERF_CNT_EN
    logic [31:0]  perf_hits, perf_misses, perf_wbs;
`endif

    d_cache_nway #(.WAYS(2), .SETS(4)) dut (
        .clk        (clk),
        .proc_reset (proc_reset),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_rdata (proc_rdata),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready)
`ifdef D_CACHE_PERF_CNT_EN
        ,
        .perf_hits  (perf_hits),
        .perf_misses(perf_misses),
        .perf_wbs   (perf_wbs)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural block memory ----------------
    logic [127:0] img [logic [27:0]];
    int           obs_cnt = 0;
    bit           obs_wr   [256];
    logic [27:0]  obs_addr [256];
    logic [127:0] obs_data [256];
    bit           both_seen = 1'b0;
    int           stray_req = 0;
    int           stray_done = 0;

    function automatic logic [127:0] dflt_blk(input logic [27:0] a);
        logic [127:0] b;
        logic [1:0]   kk;
        if (a == 28'h4) return 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        b = '0;
        for (int k = 0; k < 4; k++) begin
            kk = 2'(k);
            b[32*k +: 32] = {8'hA5, a[19:0], 2'b00, kk};
        end
        return b;
    endfunction

    initial begin : responder
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_read && mem_write) both_seen = 1'b1;
            if (mem_ready) mem_ready = 1'b0;
            if (proc_reset || !(mem_read || mem_write)) begin
                cnt = 0;
                if (!proc_reset && (stray_req != stray_done)) begin
                    mem_ready = 1'b1;
                    stray_done++;
                end
            end else begin
                cnt++;
                if (cnt > LAT) begin
                    if (obs_cnt < 256) begin
                        obs_wr[obs_cnt]   = mem_write;
                        obs_addr[obs_cnt] = mem_addr;
                        obs_data[obs_cnt] = mem_wdata;
                        obs_cnt++;
                    end
                    if (mem_write) img[mem_addr] = mem_wdata;
                    else mem_rdata = img.exists(mem_addr) ? img[mem_addr] : dflt_blk(mem_addr);
                    mem_ready = 1'b1;
                    cnt       = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit          wr;
        logic [27:0] addr;
        bit          chk;
        logic [1:0]  off;
        logic [31:0] word;
    } mtx_t;

    mtx_t        exp_mem[$];
    logic [31:0] exp_rd[$];
    int          obs_rd = 0;

    task automatic reset_checks(input string tag);
        check({tag, "_stall"},  proc_stall, 0);
        check({tag, "_rdata"},  proc_rdata, 0);
        check({tag, "_memrd"},  mem_read,   0);
        check({tag, "_memwr"},  mem_write,  0);
        check({tag, "_maddr"},  mem_addr,   0);
        check({tag, "_mwdata"}, mem_wdata,  0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;
        #1;
        reset_checks("rst");
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        exp_mem.delete();
        exp_rd.delete();
        obs_rd = obs_cnt;
    endtask

    task automatic access(input bit rd, input bit wr, input logic [29:0] addr,
                          input logic [31:0] wdata, input bit miss, input bit wb,
                          input logic [27:0] wb_addr, input logic [31:0] wb_word,
                          input logic [31:0] rdata, input string name);
        mtx_t m;
        int   n;
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        proc_wdata = wdata;
        if (wb) exp_mem.push_back('{1'b1, wb_addr, 1'b1, 2'd0, wb_word});
        if (miss) exp_mem.push_back('{1'b0, addr[29:2], 1'b0, 2'd0, 32'h0});
        if (rd && !wr) exp_rd.push_back(rdata);
        #1;
        check({name, "_stall0"}, proc_stall, miss);
        n = 0;
        while (proc_stall && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        if (proc_stall) begin
            check({name, "_timeout"}, proc_stall, 0);
        end else begin
            check({name, "_stall_cycles"}, n, miss ? (wb ? 2*LAT+3 : LAT+2) : 0);
            if (rd && !wr) check({name, "_rdata"}, proc_rdata, exp_rd.pop_front());
        end
        @(posedge clk);
        #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        while (obs_rd < obs_cnt) begin
            if (exp_mem.size() == 0) begin
                check({name, "_unexpected_mem"}, obs_cnt, obs_rd);
                obs_rd = obs_cnt;
            end else begin
                m = exp_mem.pop_front();
                check({name, "_mem_kind"}, obs_wr[obs_rd], m.wr);
                check({name, "_mem_addr"}, obs_addr[obs_rd], m.addr);
                if (m.chk) check({name, "_wb_word"}, obs_data[obs_rd][{m.off, 5'b0} +: 32], m.word);
                obs_rd++;
            end
        end
        check({name, "_mem_missing"}, exp_mem.size(), 0);
        exp_mem.delete();
        exp_rd.delete();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          rst;
        bit          wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        bit          miss;
        bit          wb;
        logic [27:0] wb_addr;
        logic [31:0] wb_word;
        logic [31:0] rdata;
        bit          perf;
        logic [31:0] p_hits, p_misses, p_wbs;
        string       name;
    } vec_t;

    function automatic vec_t mk(bit rst, bit wr, logic [29:0] addr, logic [31:0] wdata,
                                bit miss, bit wb, logic [27:0] wb_addr,
                                logic [31:0] wb_word, logic [31:0] rdata, string name);
        vec_t v;
        v.rst = rst;   v.wr = wr;     v.addr = addr;       v.wdata = wdata;
        v.miss = miss; v.wb = wb;     v.wb_addr = wb_addr; v.wb_word = wb_word;
        v.rdata = rdata; v.perf = 1'b0;
        v.p_hits = '0; v.p_misses = '0; v.p_wbs = '0;
        v.name = name;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        vec_t v;
        proc_reset = 1'b1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        proc_addr  = '0;
        proc_wdata = '0;

        // Cold miss, write hit, word selection
        vecs.push_back(mk(1, 0, 30'h11, 0,            1, 0, 0, 0, 32'hDDDDCCCC, "cold_rd"));
        vecs.push_back(mk(0, 1, 30'h12, 32'h12345678, 0, 0, 0, 0, 0,            "wr_hit"));
        vecs.push_back(mk(0, 0, 30'h12, 0,            0, 0, 0, 0, 32'h12345678, "rd_after_wr"));
        vecs.push_back(mk(0, 0, 30'h10, 0,            0, 0, 0, 0, 32'hBBBBAAAA, "rd_w0"));
        vecs.push_back(mk(0, 0, 30'h13, 0,            0, 0, 0, 0, 32'h44443333, "rd_w3"));
        // PLRU eviction of the clean, least recently used way
        vecs.push_back(mk(1, 0, 30'h10, 0, 1, 0, 0, 0, 32'hBBBBAAAA, "plru_fill_a"));
        vecs.push_back(mk(0, 0, 30'h20, 0, 1, 0, 0, 0, 32'hA5000080, "plru_fill_b"));
        vecs.push_back(mk(0, 0, 30'h10, 0, 0, 0, 0, 0, 32'hBBBBAAAA, "plru_touch_a"));
        vecs.push_back(mk(0, 0, 30'h30, 0, 1, 0, 0, 0, 32'hA50000C0, "plru_evict_b"));
        vecs.push_back(mk(0, 0, 30'h10, 0, 0, 0, 0, 0, 32'hBBBBAAAA, "plru_keep_a"));
        vecs.push_back(mk(0, 0, 30'h21, 0, 1, 0, 0, 0, 32'hA5000081, "plru_refill_b"));
        vecs.push_back(mk(0, 0, 30'h15, 0, 1, 0, 0, 0, 32'hA5000051, "set1_fill"));
        vecs.push_back(mk(0, 0, 30'h11, 0, 0, 0, 0, 0, 32'hDDDDCCCC, "set0_intact"));
        // Dirty writeback; written-back data is refetched later
        vecs.push_back(mk(1, 1, 30'h10, 32'hCAFEF00D, 1, 0, 0, 0, 0, "dwb_store_miss"));
        vecs.push_back(mk(0, 0, 30'h20, 0, 1, 0, 0, 0, 32'hA5000080, "dwb_fill_b"));
        vecs.push_back(mk(0, 0, 30'h20, 0, 0, 0, 0, 0, 32'hA5000080, "dwb_touch_b"));
        v = mk(0, 0, 30'h30, 0, 1, 1, 28'h4, 32'hCAFEF00D, 32'hA50000C0, "dwb_evict");
        v.perf = 1'b1; v.p_hits = 1; v.p_misses = 3; v.p_wbs = 1;
        vecs.push_back(v);
        vecs.push_back(mk(0, 0, 30'h11, 0, 1, 0, 0, 0, 32'hDDDDCCCC, "dwb_refill_w1"));
        vecs.push_back(mk(0, 0, 30'h10, 0, 0, 0, 0, 0, 32'hCAFEF00D, "dwb_wb_data"));

        #1;
        reset_checks("por");

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            access(!vecs[i].wr, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].miss,
                   vecs[i].wb, vecs[i].wb_addr, vecs[i].wb_word, vecs[i].rdata, vecs[i].name);
`ifdef D_CACHE_PERF_CNT_EN
            if (vecs[i].perf) begin
                check({vecs[i].name, "_perf_hits"},   perf_hits,   vecs[i].p_hits);
                check({vecs[i].name, "_perf_misses"}, perf_misses, vecs[i].p_misses);
                check({vecs[i].name, "_perf_wbs"},    perf_wbs,    vecs[i].p_wbs);
            end
`endif
        end

        // Stray mem_ready while idle must be ignored
        stray_req++;
        repeat (3) @(negedge clk);
        #1;
        check("stray_stall", proc_stall, 0);
        check("stray_memrd", mem_read,   0);
        check("stray_memwr", mem_write,  0);
        access(1, 0, 30'h10, 0, 0, 0, 0, 0, 32'hCAFEF00D, "stray_hit");

        // Read and write together behave as a write
        access(1, 1, 30'h13, 32'h5A5A5A5A, 0, 0, 0, 0, 0, "rw_both");
        access(1, 0, 30'h13, 0, 0, 0, 0, 0, 32'h5A5A5A5A, "rw_both_rd");

        // Reset in the middle of a writeback discards the dirty block
        do_reset();
        access(0, 1, 30'h10, 32'h0BADF00D, 1, 0, 0, 0, 0, "mwb_store");
        access(1, 0, 30'h20, 0, 1, 0, 0, 0, 32'hA5000080, "mwb_fill_b");
        access(1, 0, 30'h20, 0, 0, 0, 0, 0, 32'hA5000080, "mwb_touch_b");
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h30;
        begin
            int n;
            n = 0;
            #1;
            while (!mem_write && n < 20) begin
                n++;
                @(negedge clk);
                #1;
            end
        end
        check("mwb_in_wb", mem_write, 1);
        check("mwb_wb_addr", mem_addr, 28'h4);
        #2;
        proc_reset = 1'b1;
        #1;
        reset_checks("mwb_rst");
        @(negedge clk);
        proc_read = 1'b0;
        @(negedge clk);
        proc_reset = 1'b0;
        exp_mem.delete();
        exp_rd.delete();
        obs_rd = obs_cnt;
        access(1, 0, 30'h10, 0, 1, 0, 0, 0, 32'hCAFEF00D, "mwb_reread");
`ifdef D_CACHE_PERF_CNT_EN
        check("mwb_perf_misses", perf_misses, 1);
        check("mwb_perf_wbs",    perf_wbs,    0);
`endif

        check("rw_exclusive", both_seen, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/d_cache_nway.md
Name: d_cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate data cache; successor to the fixed 2-way D-cache.
- Sits between the pipeline MEM stage (30-bit word address) and the 128-bit block memory interface.
- Generalised in associativity and set count.
- Adds tree pseudo-LRU replacement, invalid-way-first fill and an optional performance-counter block.

Parameters:
- WAYS, 2, associativity; legal values 1, 2, 4, 8.
- SETS, 4, number of sets; power of two, 2..64.
- IDX_W, log2(SETS), derived (localparam).
- TAG_W, 28-IDX_W, derived (localparam).

Ports:
- clk  in  1  single clock, rising edge
- proc_reset  in  1  asynchronous, active-high reset
- proc_read  in  1  load request
- proc_write  in  1  store request
- proc_addr  in  30  word address; [1:0] word offset, [IDX_W+1:2] index, [29:IDX_W+2] tag
- proc_rdata  out  32  load data
- proc_wdata  in  32  store data
- proc_stall  out  1  high while a request cannot complete this cycle
- mem_read  out  1  block fill request
- mem_write  out  1  block writeback request
- mem_addr  out  28  block address {tag,index}
- mem_rdata  in  128  fill data; word k at bits [32k+31:32k]
- mem_wdata  out  128  writeback data
- mem_ready  in  1  memory completion strobe

Behaviour:
- Reset (async, immediate): all valid, dirty and PLRU bits clear; FSM to IDLE; mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0, proc_rdata=0, proc_stall=0. Reset mid-transaction aborts it; dirty data is discarded.
- FSM states: IDLE, WB, FILL.
- IDLE, hit (valid && tag match in any way):
  - proc_stall=0 combinationally.
  - Read: proc_rdata = selected word, same cycle.
  - Write: the word is updated at the clock edge and dirty is set.
  - PLRU for the set is updated to mark the hit way most-recent.
- IDLE, miss:
  - proc_stall=1 combinationally.
  - Victim = lowest-index invalid way, otherwise the PLRU victim.
  - Victim dirty -> WB, else -> FILL.
- WB:
  - mem_write=1, mem_addr={victim tag,index}, mem_wdata=victim block; all held stable.
  - On mem_ready=1: clear the victim's dirty bit -> FILL.
- FILL:
  - mem_read=1, mem_addr=proc_addr[29:2].
  - On mem_ready=1: write mem_rdata into the victim way, set tag, valid=1, dirty=0 -> IDLE.
  - The retried access then hits. A store merges its word and sets dirty that cycle.
- mem_read and mem_write are never high together. Each is deasserted in the cycle after mem_ready is sampled.
- mem_ready while idle or in the wrong state is ignored.
- proc_read && proc_write together is treated as a write.
- No request: proc_stall=0, no state change, PLRU unchanged.
- Miss latency with mem_ready returned after L cycles: clean miss L+2 cycles of stall, dirty miss 2L+3.
- PLRU: WAYS-1 bits per set, binary tree. WAYS=1 degenerates to direct-mapped with no PLRU storage.
- Victim choice is latched on entering WB/FILL; it is not recomputed mid-miss.
- Request inputs must stay stable while proc_stall=1; the block relies on this.

Optional Feature:
- Macro D_CACHE_PERF_CNT_EN.
- Defined: adds outputs perf_hits, perf_misses and perf_wbs (32 bits each).
  - perf_hits/perf_misses count each request once, on its first IDLE cycle; retries after a fill are not counted.
  - perf_wbs counts completed WB handshakes.
  - All three saturate at 0xFFFFFFFF and clear on proc_reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan (WAYS=2, SETS=4):
- Cold read miss:
  - Stimulus: reset, then proc_read addr 0x00000011.
  - Response: stall; mem_read, mem_addr=0x0000004. Return mem_rdata=0x44443333_22221111_DDDDCCCC_BBBBAAAA -> proc_rdata=0xDDDDCCCC, stall drops.
- Write hit:
  - Stimulus: proc_write 0x00000012 data 0x12345678.
  - Response: no stall, no memory traffic; read 0x12 returns 0x12345678.
- PLRU eviction:
  - Stimulus: fill 0x10 and 0x20 (set 0), read 0x10 again, then read 0x30.
  - Response: 0x20's way is replaced, with no writeback since it is clean. A re-read of 0x10 hits.
- Dirty writeback:
  - Stimulus: write 0x10, fill 0x20, touch 0x20, then read 0x30.
  - Response: mem_write with mem_addr=0x0000004 and the written word in mem_wdata, then mem_read mem_addr=0x000000C.
- Reset mid-WB:
  - Stimulus: assert proc_reset while mem_write=1.
  - Response: mem_write=0 immediately; the next read of 0x10 misses.
- D_CACHE_PERF_CNT_EN:
  - Stimulus: run the dirty-writeback sequence.
  - Response: perf_misses=3, perf_hits=1, perf_wbs=1.
